// File: rtl/sap_cpu_core_if.sv
// Host-facing bundle for sap_cpu_core: run control, program-load port and output/status.
// The master side is the host; the core uses the slave side.
interface sap_cpu_core_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              run;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              halted;

  modport master (
    output run, prog_we, prog_addr, prog_data,
    input  out_data, out_valid, halted
  );

  modport slave (
    input  run, prog_we, prog_addr, prog_data,
    output out_data, out_valid, halted
  );
endinterface

// File: rtl/sap_cpu_core.sv
// Multi-cycle accumulator CPU with unified RAM, carry/zero flags, conditional jumps,
// a host program-load port that stalls the core, and a terminal halt state.
module sap_cpu_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input logic            clk,
  input logic            rst,
  sap_cpu_core_if.slave  bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  localparam logic [2:0] StFetch = 3'd0;
  localparam logic [2:0] StMem   = 3'd1;
  localparam logic [2:0] StEx1   = 3'd2;
  localparam logic [2:0] StEx2   = 3'd3;
  localparam logic [2:0] StEx3   = 3'd4;
  localparam logic [2:0] StHalt  = 3'd5;

  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpSta = 4'h4;
  localparam logic [3:0] OpLdi = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpJc  = 4'h7;
  localparam logic [3:0] OpJz  = 4'h8;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              c_q, c_d;
  logic              z_q, z_d;
  logic              ov_q, ov_d;

  logic [DATA_W-1:0] mem_q [Depth];

  logic              advance;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] operand_ext;
  logic [DATA_W-1:0] rd_data;
  logic              is_sub;
  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   alu_sum;
  logic              sta_we;
  logic              unused_ir_bits;

  // A host write takes priority over everything, including run.
  assign advance     = bus.run & ~bus.prog_we;
  assign opcode      = ir_q[DATA_W-1 -: 4];
  assign operand     = ir_q[ADDR_W-1:0];
  assign operand_ext = {{(DATA_W - ADDR_W){1'b0}}, operand};
  assign rd_data     = mem_q[mar_q];
  assign unused_ir_bits = ^ir_q;

  assign is_sub  = (opcode == OpSub);
  assign b_op    = is_sub ? ~b_q : b_q;
  assign alu_sum = {1'b0, a_q} + {1'b0, b_op} + {{DATA_W{1'b0}}, is_sub};

  assign sta_we = advance && (state_q == StEx2) && (opcode == OpSta);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mar_d   = mar_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    z_d     = z_q;
    out_d   = out_q;
    // A pending pulse survives host-write stalls so it is shown exactly once.
    ov_d    = ov_q & bus.prog_we;
    if (advance) begin
      case (state_q)
        StFetch: begin
          mar_d   = pc_q;
          state_d = StMem;
        end
        StMem: begin
          ir_d    = rd_data;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StEx1;
        end
        StEx1: begin
          state_d = StFetch;
          case (opcode)
            OpLda, OpAdd, OpSub, OpSta: begin
              mar_d   = operand;
              state_d = StEx2;
            end
            OpLdi: a_d = operand_ext;
            OpJmp: pc_d = operand;
            OpJc:  if (c_q) pc_d = operand;
            OpJz:  if (z_q) pc_d = operand;
            OpOut: begin
              out_d = a_q;
              ov_d  = 1'b1;
            end
            OpHlt:   state_d = StHalt;
            default: ;
          endcase
        end
        StEx2: begin
          state_d = StFetch;
          if (opcode == OpLda) begin
            a_d = rd_data;
          end else if (opcode == OpAdd || opcode == OpSub) begin
            b_d     = rd_data;
            state_d = StEx3;
          end
        end
        StEx3: begin
          a_d     = alu_sum[DATA_W-1:0];
          c_d     = alu_sum[DATA_W];
          z_d     = (alu_sum[DATA_W-1:0] == '0);
          state_d = StFetch;
        end
        StHalt:  state_d = StHalt;
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= '0;
      mar_q   <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      z_q     <= z_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

  // RAM has no reset; STA cannot fire while rst holds the sequencer in FETCH.
  always_ff @(posedge clk) begin
    if (bus.prog_we) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end else if (sta_we) begin
      mem_q[mar_q] <= a_q;
    end
  end

  assign bus.out_data  = out_q;
  assign bus.out_valid = ov_q & ~bus.prog_we;
  assign bus.halted    = (state_q == StHalt);

endmodule

// File: tb/tb_sap_cpu_core.sv
// Directed bench for sap_cpu_core: default 8/4 instance plus a 12/8 instance for
// width and address-wrap coverage.
module tb_sap_cpu_core;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  sap_cpu_core_if #(.DATA_W(8),  .ADDR_W(4)) bus   ();
  sap_cpu_core_if #(.DATA_W(12), .ADDR_W(8)) bus12 ();

  sap_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sap_cpu_core #(.DATA_W(12), .ADDR_W(8)) dut12 (
    .clk (clk),
    .rst (rst),
    .bus (bus12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] img [16];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    bus.run        = 1'b0;
    bus.prog_we    = 1'b0;
    bus12.run      = 1'b0;
    bus12.prog_we  = 1'b0;
    #2 rst = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
  endtask

  task automatic load8();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.prog_we   = 1'b1;
      bus.prog_addr = 4'(i);
      bus.prog_data = img[i];
    end
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  task automatic load12(input logic [7:0] a, input logic [11:0] d);
    @(negedge clk);
    bus12.prog_we   = 1'b1;
    bus12.prog_addr = a;
    bus12.prog_data = d;
    @(posedge clk);
    #1 bus12.prog_we = 1'b0;
  endtask

  // Runs the 8-bit core until halted; counts clock edges and out_valid pulses.
  task automatic run_to_halt(input int max_cyc, input bit stall, output int cycles,
                             output int pulses, output logic [7:0] last_out,
                             output int collisions);
    cycles = 0; pulses = 0; last_out = 8'h00; collisions = 0;
    bus.run = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      if (stall) begin
        bus.run       = ($urandom_range(0, 3) != 0);
        bus.prog_we   = ($urandom_range(0, 4) == 0);
        bus.prog_addr = 4'(10 + $urandom_range(0, 1));
        bus.prog_data = 8'($urandom);
      end
      #1;
      if (bus.out_valid && bus.prog_we) collisions++;
      if (bus.out_valid) begin
        pulses++;
        last_out = bus.out_data;
      end
      if (bus.halted) break;
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    bus.prog_we = 1'b0;
    bus.run     = 1'b0;
    check_eq("halt_reached", {31'd0, bus.halted}, 32'd1);
  endtask

  int          cyc, pulses, coll;
  logic [7:0]  last;
  logic [11:0] last12;
  int          pulses12;
  bit          seen;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.run = 1'b0;   bus.prog_we = 1'b0;   bus.prog_addr = '0;   bus.prog_data = '0;
    bus12.run = 1'b0; bus12.prog_we = 1'b0; bus12.prog_addr = '0; bus12.prog_data = '0;
    do_reset();

    // Reset state
    check_eq("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_halted", {31'd0, bus.halted}, 32'd0);
    check_eq("rst_pc", {28'd0, dut.pc_q}, 32'd0);
    check_eq("rst_state", {29'd0, dut.state_q}, 32'd0);

    // Add/out program: 5 + 3 = 8, 15 cycles total
    clear_img();
    img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
    img[14] = 8'h05; img[15] = 8'h03;
    load8();
    run_to_halt(100, 1'b0, cyc, pulses, last, coll);
    check_eq("add_cycles", cyc, 32'd15);
    check_eq("add_pulses", pulses, 32'd1);
    check_eq("add_out", {24'd0, last}, 32'h08);

    // Stalled rerun of the same program must give identical results
    do_reset();
    load8();
    run_to_halt(2000, 1'b1, cyc, pulses, last, coll);
    check_eq("stall_pulses", pulses, 32'd1);
    check_eq("stall_out", {24'd0, last}, 32'h08);
    check_eq("stall_ov_vs_we", coll, 32'd0);

    // Carry/zero flags and conditional jumps
    do_reset();
    clear_img();
    img[0] = 8'h5F; img[1] = 8'h2C; img[2] = 8'h76; img[3] = 8'hF0;
    img[6] = 8'h52; img[7] = 8'h3D; img[8] = 8'h83; img[9] = 8'hE0; img[10] = 8'hF0;
    img[12] = 8'hF1; img[13] = 8'h03;
    load8();
    bus.run = 1'b1;
    step(8);
    check_eq("add_a", {24'd0, dut.a_q}, 32'h00);
    check_eq("add_c", {31'd0, dut.c_q}, 32'd1);
    check_eq("add_z", {31'd0, dut.z_q}, 32'd1);
    step(3);
    check_eq("jc_pc", {28'd0, dut.pc_q}, 32'd6);
    step(8);
    check_eq("sub_a", {24'd0, dut.a_q}, 32'hFF);
    check_eq("sub_c", {31'd0, dut.c_q}, 32'd0);
    check_eq("sub_z", {31'd0, dut.z_q}, 32'd0);
    step(3);
    check_eq("jz_not_taken_pc", {28'd0, dut.pc_q}, 32'd9);
    run_to_halt(100, 1'b0, cyc, pulses, last, coll);
    check_eq("flags_out", {24'd0, last}, 32'hFF);

    // STA/LDA round trip
    do_reset();
    clear_img();
    img[0] = 8'h59; img[1] = 8'h4D; img[2] = 8'h50; img[3] = 8'h1D;
    img[4] = 8'hE0; img[5] = 8'hF0;
    load8();
    run_to_halt(100, 1'b0, cyc, pulses, last, coll);
    check_eq("sta_lda_out", {24'd0, last}, 32'h09);
    check_eq("sta_ram13", {24'd0, dut.mem_q[13]}, 32'h09);
    check_eq("sta_lda_cycles", cyc, 32'd3 + 32'd4 + 32'd3 + 32'd4 + 32'd3 + 32'd3);

    // Asynchronous reset in the middle of ADD (after an OUT has set out_data=5)
    clear_img();
    img[0] = 8'h55; img[1] = 8'hE0; img[2] = 8'h2F; img[3] = 8'hF0; img[15] = 8'h03;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      load8();
      bus.run = 1'b1;
      step(6 + $urandom_range(1, 4));
      #2 rst = 1'b1;
      #1;
      check_eq("midrst_out_data", {24'd0, bus.out_data}, 32'd0);
      check_eq("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check_eq("midrst_halted", {31'd0, bus.halted}, 32'd0);
      check_eq("midrst_state", {29'd0, dut.state_q}, 32'd0);
      check_eq("midrst_a", {24'd0, dut.a_q}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step(2);
      check_eq("midrst_first_ir", {24'd0, dut.ir_q}, 32'h55);
      check_eq("midrst_first_pc", {28'd0, dut.pc_q}, 32'd1);
      bus.run = 1'b0;
    end

    // 12-bit core: countdown from 300 by SUB 1, then LDA/OUT a marker
    do_reset();
    for (int i = 0; i < 256; i++) load12(8'(i), 12'h000);
    load12(8'd0, 12'h1C8);
    load12(8'd1, 12'h3C9);
    load12(8'd2, 12'h804);
    load12(8'd3, 12'h601);
    load12(8'd4, 12'h1CA);
    load12(8'd5, 12'hE00);
    load12(8'd6, 12'hF00);
    load12(8'd200, 12'd300);
    load12(8'd201, 12'd1);
    load12(8'd202, 12'hABC);
    @(negedge clk);
    cyc = 0; pulses12 = 0; last12 = '0;
    bus12.run = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      #1;
      if (bus12.out_valid) begin
        pulses12++;
        last12 = bus12.out_data;
      end
      if (bus12.halted) break;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check_eq("w12_halted", {31'd0, bus12.halted}, 32'd1);
    check_eq("w12_cycles", cyc, 32'd3311);
    check_eq("w12_pulses", pulses12, 32'd1);
    check_eq("w12_out", {20'd0, last12}, 32'hABC);
    check_eq("w12_c_after_loop", {31'd0, dut12.c_q}, 32'd1);

    // 12-bit core: NOP-filled RAM, PC must wrap 255 -> 0
    do_reset();
    for (int i = 0; i < 7; i++) load12(8'(i), 12'h000);
    @(negedge clk);
    bus12.run = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (dut12.pc_q == 8'd255) begin
        seen = 1'b1;
        break;
      end
      step(1);
    end
    check_eq("pc_reached_255", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (dut12.pc_q != 8'd255) break;
      step(1);
    end
    check_eq("pc_wrap_to_0", {24'd0, dut12.pc_q}, 32'd0);
    bus12.run = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sap_cpu_core.md
# sap_cpu_core

Parametrised multi-cycle accumulator CPU core: the next generation of the team's 8-bit bus-based CPU, generalised in data width and memory depth. Contains PC, MAR, IR, A, B, ALU with carry/zero flags, unified program/data RAM, an output register and a variable-length control sequencer. Adds three things the 8-bit CPU lacks: conditional jumps, a host program-load port, and a halt state. Sits at top level; a host loads RAM, then releases `run`.

## Interface
- `DATA_W`, default 8: data, register and RAM word width; must be ≥ `ADDR_W`+4.
- `ADDR_W`, default 4: RAM address width; RAM depth is 2^`ADDR_W` words.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `run`  in  1  1 = sequencer advances; 0 = all state holds.
- `prog_we`  in  1  host RAM write strobe.
- `prog_addr`  in  `ADDR_W`  host write address.
- `prog_data`  in  `DATA_W`  host write data.
- `out_data`  out  `DATA_W`  output register.
- `out_valid`  out  1  one-cycle pulse when `out_data` is updated by OUT.
- `halted`  out  1  high once HLT has executed.

## Operation
- Instruction word: opcode = bits [`DATA_W`-1 -: 4]; operand = bits [`ADDR_W`-1:0].
- Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JC, 8 JZ, E OUT, F HLT. 9–D execute as NOP.
- States: FETCH, MEM, EX1, EX2, EX3, HALT.
- FETCH: MAR←PC; →MEM.
- MEM: IR←RAM[MAR]; PC←PC+1 (wraps 2^`ADDR_W`-1→0); →EX1.
- EX1:
  - LDA/ADD/SUB/STA: MAR←operand; →EX2.
  - LDI: A←operand, zero-extended; →FETCH.
  - JMP: PC←operand. JC: PC←operand if C=1. JZ: PC←operand if Z=1. All →FETCH.
  - OUT: out_data←A; out_valid=1 next cycle; →FETCH.
  - HLT: →HALT. NOP/undefined: →FETCH.
- EX2:
  - LDA: A←RAM[MAR]; →FETCH. Flags unchanged.
  - STA: RAM[MAR]←A; →FETCH.
  - ADD/SUB: B←RAM[MAR]; →EX3.
- EX3:
  - ADD: {C,A}←A+B.
  - SUB: {C,A}←A+~B+1, so C=1 means no borrow (A≥B).
  - Z←(new A==0). Then →FETCH.
- Only ADD/SUB write C and Z.
- HALT: the only exit is `rst`. `halted`=1. The host port stays usable.
- Host port: when `prog_we`=1, RAM[prog_addr]←prog_data and the core stalls that cycle. The stall holds all registers and state and forces `out_valid`=0. This ignores `run`, so a host write can never collide with STA. Loading is intended with `run`=0 or while halted.

## Timing
- Reset values: PC, MAR, IR, A, B, C, Z = 0; state=FETCH; out_data=0; out_valid=0; halted=0. RAM contents are not reset.
- Reset is asynchronous mid-instruction. A pending STA is abandoned.
- RAM read is synchronous, one cycle: the address is registered in MAR, and the data is used in the next state.
- Instruction cycle counts with `run`=1 and no stalls:
  - NOP/LDI/JMP/JC/JZ/OUT/undefined: 3.
  - LDA/STA: 4.
  - ADD/SUB: 5.
  - HLT: 3 to reach HALT; `halted` rises on the edge entering HALT.
- `out_valid` is registered. It is high for exactly the one cycle after the EX1 of OUT.
- `run`=0 or `prog_we`=1 inserts stall cycles anywhere, without changing results.
- A jump taken on the instruction at address 2^`ADDR_W`-1 behaves as normal. Sequential fetch past the last address wraps to 0.

## Test plan
- Reset check: assert `rst` mid-ADD at random cycles → all outputs 0 and state FETCH within the same cycle; after release, the first fetch is from address 0.
- Add/out program (defaults): load `0x1E,0x2F,0xE0,0xF0`, RAM[14]=0x05, RAM[15]=0x03, `run`=1. Expect `out_valid` once with out_data=0x08, then `halted`=1. Total cycles = 4+5+3+3 = 15.
- Carry/zero flags: LDI 0xF, ADD RAM=0xF1 → A=0x00, C=1, Z=1. Then JC 6 → PC=6. SUB with A=0x02, B=0x03 → A=0xFF, C=0, Z=0, and JZ not taken.
- STA/LDA round trip: LDI 9, STA 13, LDI 0, LDA 13, OUT → out_data=0x09. RAM[13]=0x09 is readable by the bench.
- Stall behaviour: toggle `run` randomly and issue `prog_we` writes to unused addresses mid-program → same out_data sequence as the unstalled run, and `out_valid` never high during a `prog_we` cycle.
- Parametrisation: `DATA_W`=12, `ADDR_W`=8; a countdown loop from 300 by SUB 1 with JZ exit wraps correctly. PC wrap check: NOP-filled RAM → PC sequence 255→0.
